// File: rtl/echo_pipe_pkg.sv
// Shared definitions for the EchoIndication pipe link: method ids, per-method
// message lengths, header layout and the demarshaller state encoding.
package echo_pipe_pkg;

    localparam int HDR_ID_W  = 16;
    localparam int HDR_LEN_W = 16;

    localparam logic [HDR_ID_W-1:0] METHOD_HEARD  = 16'd0;
    localparam logic [HDR_ID_W-1:0] METHOD_HEARD2 = 16'd1;
    localparam logic [HDR_ID_W-1:0] METHOD_HEARD3 = 16'd2;

    // Total beats per message, header included
    localparam logic [HDR_LEN_W-1:0] LEN_HEARD  = 16'd2;
    localparam logic [HDR_LEN_W-1:0] LEN_HEARD2 = 16'd3;
    localparam logic [HDR_LEN_W-1:0] LEN_HEARD3 = 16'd5;

    typedef struct packed {
        logic [HDR_ID_W-1:0]  id;
        logic [HDR_LEN_W-1:0] len;
    } echo_hdr_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COLLECT  = 2'd1,
        ST_DISPATCH = 2'd2,
        ST_DROP     = 2'd3
    } p2m_state_t;

    function automatic logic hdr_is_legal(input echo_hdr_t h);
        case (h.id)
            METHOD_HEARD:  return h.len == LEN_HEARD;
            METHOD_HEARD2: return h.len == LEN_HEARD2;
            METHOD_HEARD3: return h.len == LEN_HEARD3;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/p2m_beat_collector.sv
// Beat bookkeeping for the demarshaller: remaining-beat counter shared by
// collect and drop, plus the 4x32 argument register file.
module p2m_beat_collector
    import echo_pipe_pkg::*;
(
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 i_load,
    input  logic [HDR_LEN_W-1:0] i_remaining,
    input  logic                 i_beat,
    input  logic                 i_store,
    input  logic [31:0]          i_data,
    output logic                 o_last,
    output logic [31:0]          o_arg0,
    output logic [31:0]          o_arg1,
    output logic [31:0]          o_arg2,
    output logic [31:0]          o_arg3
);

    logic [HDR_LEN_W-1:0] r_remaining;
    logic [1:0]           r_idx;
    logic [3:0][31:0]     r_args;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_remaining <= '0;
            r_idx       <= '0;
            r_args      <= '0;
        end else if (i_load) begin
            r_remaining <= i_remaining;
            r_idx       <= '0;
        end else if (i_beat) begin
            r_remaining <= r_remaining - 16'd1;
            // Dropped beats only count down; they never touch the arguments
            if (i_store) begin
                r_args[r_idx] <= i_data;
                r_idx         <= r_idx + 2'd1;
            end
        end
    end

    assign o_last = (r_remaining == 16'd1);
    assign o_arg0 = r_args[0];
    assign o_arg1 = r_args[1];
    assign o_arg2 = r_args[2];
    assign o_arg3 = r_args[3];

endmodule

// File: rtl/p2m_echo_indication.sv
// EchoIndication pipe demarshaller: rebuilds header+argument beats and calls
// heard/heard2/heard3. Define P2M_ERROR_COUNT_EN to add the err_count port.
module p2m_echo_indication
    import echo_pipe_pkg::*;
#(
    parameter int ERR_WIDTH = 8,
    parameter int MAX_LEN   = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        pipe_enq__ENA,
    input  logic [31:0] pipe_enq_v,
    output logic        pipe_enq__RDY,
    output logic        heard__ENA,
    output logic [31:0] heard_v,
    input  logic        heard__RDY,
    output logic        heard2__ENA,
    output logic [31:0] heard2_a,
    output logic [31:0] heard2_b,
    input  logic        heard2__RDY,
    output logic        heard3__ENA,
    output logic [31:0] heard3_a,
    output logic [31:0] heard3_b,
    output logic [31:0] heard3_c,
    output logic [31:0] heard3_d,
    input  logic        heard3__RDY
`ifdef P2M_ERROR_COUNT_EN
    ,output logic [ERR_WIDTH-1:0] err_count
`endif
);

    p2m_state_t           r_state;
    logic [1:0]           r_id;
    echo_hdr_t            w_hdr;
    logic                 w_accept;
    logic                 w_legal;
    logic                 w_load;
    logic                 w_beat;
    logic                 w_last;
    logic                 w_fire;
    logic [HDR_LEN_W-1:0] w_rem;
    logic [31:0]          w_arg0, w_arg1, w_arg2, w_arg3;

    assign pipe_enq__RDY = nRST & (r_state != ST_DISPATCH);
    assign w_accept      = pipe_enq__ENA & pipe_enq__RDY;
    assign w_hdr         = echo_hdr_t'(pipe_enq_v);
    assign w_legal       = hdr_is_legal(w_hdr);
    assign w_load        = w_accept & (r_state == ST_IDLE) & (w_hdr.len > 16'd1);
    assign w_beat        = w_accept & ((r_state == ST_COLLECT) | (r_state == ST_DROP));

    // Oversized headers only swallow MAX_LEN beats so a corrupt length cannot stall the link
    assign w_rem = (!w_legal && (w_hdr.len > 16'(MAX_LEN))) ? 16'(MAX_LEN - 1)
                                                            : w_hdr.len - 16'd1;

    // Only the selected method raises ENA, so the other RDYs drop out here
    assign w_fire = (heard__ENA & heard__RDY) | (heard2__ENA & heard2__RDY) |
                    (heard3__ENA & heard3__RDY);

    p2m_beat_collector u_collector (
        .CLK         (CLK),
        .nRST        (nRST),
        .i_load      (w_load),
        .i_remaining (w_rem),
        .i_beat      (w_beat),
        .i_store     (r_state == ST_COLLECT),
        .i_data      (pipe_enq_v),
        .o_last      (w_last),
        .o_arg0      (w_arg0),
        .o_arg1      (w_arg1),
        .o_arg2      (w_arg2),
        .o_arg3      (w_arg3)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state     <= ST_IDLE;
            r_id        <= '0;
            heard__ENA  <= 1'b0;
            heard2__ENA <= 1'b0;
            heard3__ENA <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_legal) begin
                        r_id    <= w_hdr.id[1:0];
                        r_state <= ST_COLLECT;
                    end else if (w_load) begin
                        r_state <= ST_DROP;
                    end
                end
                ST_COLLECT: begin
                    if (w_beat && w_last) begin
                        heard__ENA  <= (r_id == METHOD_HEARD[1:0]);
                        heard2__ENA <= (r_id == METHOD_HEARD2[1:0]);
                        heard3__ENA <= (r_id == METHOD_HEARD3[1:0]);
                        r_state     <= ST_DISPATCH;
                    end
                end
                ST_DISPATCH: begin
                    if (w_fire) begin
                        heard__ENA  <= 1'b0;
                        heard2__ENA <= 1'b0;
                        heard3__ENA <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (w_beat && w_last) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign heard_v  = w_arg0;
    assign heard2_a = w_arg0;
    assign heard2_b = w_arg1;
    assign heard3_a = w_arg0;
    assign heard3_b = w_arg1;
    assign heard3_c = w_arg2;
    assign heard3_d = w_arg3;

`ifdef P2M_ERROR_COUNT_EN
    logic                 w_bad_hdr;
    logic [ERR_WIDTH-1:0] r_err_count;

    assign w_bad_hdr = w_accept & (r_state == ST_IDLE) & ~w_legal;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_err_count <= '0;
        end else if (w_bad_hdr && (r_err_count != {ERR_WIDTH{1'b1}})) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign err_count = r_err_count;
`else
    // ERR_WIDTH only sizes the counter; keep the parameter referenced without it
    if (ERR_WIDTH < 1) begin : g_err_width_unused
    end
`endif

endmodule

// File: tb/tb_p2m_echo_indication.sv
// Randomized bench for p2m_echo_indication with a message-level reference model.
// Build with P2M_ERROR_COUNT_EN defined to also check err_count.
module tb_p2m_echo_indication;

    localparam int MAX_LEN   = 16;
    localparam int ERR_WIDTH = 8;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        pipe_enq__ENA = 1'b0;
    logic [31:0] pipe_enq_v = '0;
    logic        pipe_enq__RDY;
    logic        heard__ENA, heard2__ENA, heard3__ENA;
    logic        heard__RDY = 1'b0, heard2__RDY = 1'b0, heard3__RDY = 1'b0;
    logic [31:0] heard_v, heard2_a, heard2_b, heard3_a, heard3_b, heard3_c, heard3_d;
`ifdef P2M_ERROR_COUNT_EN
    logic [ERR_WIDTH-1:0] err_count;
`endif

    always #5 CLK = ~CLK;

    p2m_echo_indication #(.ERR_WIDTH(ERR_WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .CLK(CLK), .nRST(nRST),
        .pipe_enq__ENA(pipe_enq__ENA), .pipe_enq_v(pipe_enq_v), .pipe_enq__RDY(pipe_enq__RDY),
        .heard__ENA(heard__ENA), .heard_v(heard_v), .heard__RDY(heard__RDY),
        .heard2__ENA(heard2__ENA), .heard2_a(heard2_a), .heard2_b(heard2_b), .heard2__RDY(heard2__RDY),
        .heard3__ENA(heard3__ENA), .heard3_a(heard3_a), .heard3_b(heard3_b),
        .heard3_c(heard3_c), .heard3_d(heard3_d), .heard3__RDY(heard3__RDY)
`ifdef P2M_ERROR_COUNT_EN
        , .err_count(err_count)
`endif
    );

    int unsigned    n_checks = 0;
    int unsigned    n_errors = 0;
    int unsigned    n_calls = 0;
    int unsigned    model_err = 0;
    int             cyc = 0;
    int             rdy_mode = 1;   // 0 random, 1 all high, 2 heard3 held low
    bit             gap_en = 1'b0;
    logic [129:0]   exp_q[$];       // {method[1:0], a3, a2, a1, a0}
    int             hs_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Sink-side RDY driver
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            case (rdy_mode)
                0: begin
                    heard__RDY  = ($urandom_range(0, 3) != 0);
                    heard2__RDY = ($urandom_range(0, 3) != 0);
                    heard3__RDY = ($urandom_range(0, 3) != 0);
                end
                2: begin
                    heard__RDY = 1'b1; heard2__RDY = 1'b1; heard3__RDY = 1'b0;
                end
                default: begin
                    heard__RDY = 1'b1; heard2__RDY = 1'b1; heard3__RDY = 1'b1;
                end
            endcase
        end
    end

    // Call monitor: every completed method handshake is matched to the model queue
    always @(negedge CLK) begin
        if (nRST) begin
            if (heard__ENA || heard2__ENA || heard3__ENA) begin
                check("ena_onehot", 32'($countones({heard__ENA, heard2__ENA, heard3__ENA})), 32'd1);
                check("pipe_rdy_in_dispatch", 32'(pipe_enq__RDY), 32'd0);
            end
            if ((heard__ENA && heard__RDY) || (heard2__ENA && heard2__RDY) ||
                (heard3__ENA && heard3__RDY)) begin
                logic [129:0] e;
                logic [1:0]   m;
                hs_q.push_back(cyc);
                n_calls++;
                m = heard__ENA ? 2'd0 : (heard2__ENA ? 2'd1 : 2'd2);
                if (exp_q.size() == 0) begin
                    check("unexpected_call", 32'(m), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("call_method", 32'(m), 32'(e[129:128]));
                    if (m == 2'd0) begin
                        check("heard_v", heard_v, e[31:0]);
                    end else if (m == 2'd1) begin
                        check("heard2_a", heard2_a, e[31:0]);
                        check("heard2_b", heard2_b, e[63:32]);
                    end else begin
                        check("heard3_a", heard3_a, e[31:0]);
                        check("heard3_b", heard3_b, e[63:32]);
                        check("heard3_c", heard3_c, e[95:64]);
                        check("heard3_d", heard3_d, e[127:96]);
                    end
                end
            end
        end
    end

    function automatic int unsigned model_len(input int unsigned id);
        case (id)
            0: return 2;
            1: return 3;
            2: return 5;
            default: return 0;
        endcase
    endfunction

    task automatic send_beat(input logic [31:0] data);
        bit ok = 1'b0;
        if (gap_en && $urandom_range(0, 3) == 0) begin
            pipe_enq__ENA = 1'b0;
            pipe_enq_v = $urandom;
            repeat ($urandom_range(1, 3)) @(posedge CLK);
            #1;
        end
        pipe_enq__ENA = 1'b1;
        pipe_enq_v = data;
        for (int t = 0; t < 200 && !ok; t++) begin
            if (CLK) @(negedge CLK);
            if (pipe_enq__RDY) ok = 1'b1;
            @(posedge CLK);
            #1;
        end
        if (!ok) check("beat_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_msg(input int unsigned id, input int unsigned len,
                            input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] a2, input logic [31:0] a3);
        logic [31:0] args[4];
        bit          legal;
        int unsigned nbeats;
        args[0] = a0; args[1] = a1; args[2] = a2; args[3] = a3;
        legal = (model_len(id) != 0) && (len == model_len(id));
        if (legal)             nbeats = len - 1;
        else if (len <= 1)     nbeats = 0;
        else if (len > MAX_LEN) nbeats = MAX_LEN - 1;
        else                   nbeats = len - 1;
        if (legal) exp_q.push_back({2'(id), a3, a2, a1, a0});
        else if (model_err < (1 << ERR_WIDTH) - 1) model_err++;
        send_beat({16'(id), 16'(len)});
        for (int i = 0; i < int'(nbeats); i++)
            send_beat(legal ? args[i] : $urandom);
        if (legal) begin
            @(negedge CLK);
            check("ena_latency", 32'({heard3__ENA, heard2__ENA, heard__ENA}), 32'(1 << id));
        end
        pipe_enq__ENA = 1'b0;
`ifdef P2M_ERROR_COUNT_EN
        check("err_count", 32'(err_count), model_err);
`endif
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 400 && exp_q.size() != 0; t++) @(negedge CLK);
        @(negedge CLK);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int unsigned calls_before;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_pipe_rdy", 32'(pipe_enq__RDY), 32'd0);
        check("rst_enas", 32'({heard__ENA, heard2__ENA, heard3__ENA}), 32'd0);
        check("rst_heard_v", heard_v, 32'd0);
        check("rst_heard3_d", heard3_d, 32'd0);
`ifdef P2M_ERROR_COUNT_EN
        check("rst_err_count", 32'(err_count), 32'd0);
`endif
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(negedge CLK);
        check("pipe_rdy_after_rst", 32'(pipe_enq__RDY), 32'd1);

        // heard with immediate acceptance: ENA lasts exactly one cycle
        rdy_mode = 1;
        send_msg(0, 2, 32'hDEAD_BEEF, 0, 0, 0);
        check("heard_only_ena", 32'({heard2__ENA, heard3__ENA}), 32'd0);
        @(negedge CLK);
        check("heard_one_cycle", 32'(heard__ENA), 32'd0);

        // heard3 with sink back-pressure for three cycles
        rdy_mode = 2;
        send_msg(2, 5, 32'd1, 32'd2, 32'd3, 32'd4);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge CLK);
            check("heard3_held", 32'(heard3__ENA), 32'd1);
            check("heard3_pipe_rdy", 32'(pipe_enq__RDY), 32'd0);
            check("heard3_args", {heard3_a[7:0], heard3_b[7:0], heard3_c[7:0], heard3_d[7:0]},
                  32'h01020304);
        end
        rdy_mode = 1;
        @(negedge CLK);
        check("heard3_until_rdy", 32'(heard3__ENA), 32'd1);
        @(negedge CLK);
        check("heard3_done", 32'(heard3__ENA), 32'd0);

        // wrong length drop, then legal heard2
        send_msg(1, 5, 0, 0, 0, 0);
        send_msg(1, 3, 32'd7, 32'd9, 0, 0);
        // zero length header: error, nothing dropped
        send_msg(0, 0, 0, 0, 0, 0);
        send_msg(0, 2, 32'h1234_5678, 0, 0, 0);
        wait_drain();

        // reset in the middle of a heard3 message
        send_beat(32'h0002_0005);
        send_beat(32'hAAAA_0001);
        send_beat(32'hAAAA_0002);
        pipe_enq__ENA = 1'b0;
        nRST = 1'b0;
        @(negedge CLK);
        check("midrst_pipe_rdy", 32'(pipe_enq__RDY), 32'd0);
        check("midrst_enas", 32'({heard__ENA, heard2__ENA, heard3__ENA}), 32'd0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        model_err = 0;
        calls_before = n_calls;
        @(negedge CLK);
        check("postrst_pipe_rdy", 32'(pipe_enq__RDY), 32'd1);
`ifdef P2M_ERROR_COUNT_EN
        check("postrst_err_count", 32'(err_count), 32'd0);
`endif
        send_msg(2, 5, 32'h11, 32'h22, 32'h33, 32'h44);
        wait_drain();
        check("postrst_calls", n_calls - calls_before, 32'd1);

        // back-to-back heard messages: one call every three cycles
        hs_q.delete();
        for (int i = 0; i < 4; i++) send_msg(0, 2, $urandom, 0, 0, 0);
        wait_drain();
        check("b2b_call_count", 32'(hs_q.size()), 32'd4);
        for (int i = 1; i < hs_q.size(); i++)
            check("b2b_period", 32'(hs_q[i] - hs_q[i-1]), 32'd3);

        // randomized traffic with random sink readiness and input gaps
        rdy_mode = 0;
        gap_en = 1'b1;
        for (int n = 0; n < 60; n++) begin
            int unsigned kind = $urandom_range(0, 3);
            if (kind < 3)
                send_msg(kind, model_len(kind), $urandom, $urandom, $urandom, $urandom);
            else
                send_msg($urandom_range(0, 3), $urandom_range(0, 20),
                         $urandom, $urandom, $urandom, $urandom);
        end
        rdy_mode = 1;
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/p2m_echo_indication.md
Name: p2m_echo_indication

Overview:
- Receive-side demarshaller for the EchoIndication pipe protocol. It is the inverse of the method-to-pipe marshaller.
- Consumes 32-bit beats from a PipeIn-style enq channel, rebuilds one message (header plus argument beats), then calls exactly one of heard/heard2/heard3 with an ENA/RDY handshake.
- Sits at the indication end of the link, in front of the user's EchoIndication implementation.

Parameters:
- ERR_WIDTH, 8, width of the saturating malformed-message counter.
- MAX_LEN, 16, largest legal header length field; larger values are treated as malformed.

Ports:
- CLK  input  1  clock
- nRST  input  1  synchronous active-low reset
- pipe_enq__ENA  input  1  beat valid
- pipe_enq_v  input  32  beat data
- pipe_enq__RDY  output  1  block can accept a beat
- heard__ENA  output  1  call heard
- heard_v  output  32  heard argument
- heard__RDY  input  1  sink accepts heard
- heard2__ENA  output  1  call heard2
- heard2_a, heard2_b  output  32 each  heard2 arguments
- heard2__RDY  input  1
- heard3__ENA  output  1  call heard3
- heard3_a, heard3_b, heard3_c, heard3_d  output  32 each  heard3 arguments
- heard3__RDY  input  1
- err_count  output  ERR_WIDTH  malformed messages seen; present only with the optional feature

Behaviour:
- Interface decision: one clock CLK; reset nRST is synchronous and active-low.
- Beat transfer occurs when pipe_enq__ENA & pipe_enq__RDY.
- Header beat layout:
  - bits [31:16] = method id (0 = heard, 1 = heard2, 2 = heard3).
  - bits [15:0] = total beats in the message, header included.
- Legal messages:
  - id 0 with length 2.
  - id 1 with length 3.
  - id 2 with length 5.
  - Argument beats arrive in order: v; a, b; a, b, c, d.
- State machine states: IDLE, COLLECT, DISPATCH, DROP.
- IDLE:
  - Accept a header.
  - Legal header: latch id, set remaining = length-1, go to COLLECT.
  - Length 0 or 1: count an error, stay in IDLE (nothing to drop).
  - Any other illegal id/length combination, with length <= MAX_LEN: count an error, set remaining = length-1, go to DROP.
  - Length > MAX_LEN: count an error, set remaining = MAX_LEN-1, go to DROP.
- COLLECT:
  - Each accepted beat is written into the argument slot indexed by beat number; remaining decrements.
  - When the last beat is accepted, go to DISPATCH.
- DISPATCH:
  - pipe_enq__RDY = 0.
  - Exactly one method ENA is held high (registered), with arguments stable.
  - On ENA & RDY of that method: drop ENA the next cycle and go to IDLE.
  - RDY of the other methods is ignored.
- DROP:
  - Accept and discard beats until remaining reaches 0, then go to IDLE.
- pipe_enq__RDY = nRST & (state != DISPATCH). It is combinational from state, never from method RDY.
- Latency:
  - First method ENA is asserted the cycle after the last argument beat is accepted.
  - Minimum message period is length+1 cycles.
- Argument registers:
  - Keep their values after dispatch until overwritten.
  - Unused argument outputs of non-selected methods are don't-care but must not glitch while ENA is high.
- Reset (nRST low at a clock edge):
  - State goes to IDLE.
  - All ENA = 0, all arguments = 0, remaining = 0, err_count = 0.
  - pipe_enq__RDY = 0 while nRST is low.
  - Reset mid-message abandons the message silently: no error is counted and no method is called.
- ENA of the pipe without RDY (only possible in DISPATCH) has no effect.
- At most one method ENA is high in any cycle.

Optional Feature:
- Macro: P2M_ERROR_COUNT_EN.
- Defined:
  - err_count port exists.
  - Increments by 1 per malformed header and saturates at all-ones.
- Undefined:
  - Port and counter are removed.
  - Malformed messages are still dropped identically.

Decomposition:
- Shared package echo_pipe_pkg holds:
  - method id constants METHOD_HEARD=0, METHOD_HEARD2=1, METHOD_HEARD3=2.
  - Per-method expected lengths 2/3/5.
  - Header field widths and a typedef for the header struct {id[15:0], len[15:0]}.
- The same package is also imported by the marshaller side.
- One natural sub-module: p2m_beat_collector. It holds the beat counter, the remaining/drop logic and the 4x32 argument register file.
- The top level keeps the state machine and the method-port dispatch.

Test Plan:
- Send header 0x00000002, then 0xDEADBEEF, with heard__RDY=1 -> heard__ENA high for one cycle with heard_v=0xDEADBEEF; no other ENA.
- Send id 2: header 0x00020005, then beats 1, 2, 3, 4, with heard3__RDY low for 3 cycles -> heard3__ENA held with a..d=1,2,3,4; pipe_enq__RDY=0 throughout; completes on the first cycle RDY=1.
- Send header 0x00010005 (wrong length) followed by 4 beats, then a legal heard2 message 0x00010003, 7, 9 -> first message dropped, err_count=1, heard2 called with a=7, b=9.
- Send header 0x00000000, then a legal heard message -> err_count increments with no beats dropped; heard called on the next message.
- Assert nRST for 1 cycle after 2 of 4 heard3 argument beats -> no ENA, state IDLE; next header parsed correctly; err_count=0.
- Send back-to-back legal heard messages with pipe_enq__ENA held high -> one heard call every 3 cycles, argument values in order.
